phase_seq_gen: RTL and testbench

//  Parametrised instruction-cycle phase sequencer for the RISC CPU; successor to the fixed 8-phase clock generator.

---
 rtl/phase_seq_gen_pkg.sv | 26 ++
 rtl/phase_window.sv | 51 +++++
 rtl/phase_seq_gen.sv | 125 ++++++++++++
 tb/tb_phase_seq_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_seq_gen_pkg.sv
// Shared types and default timing constants for the instruction-cycle phase sequencer.
package phase_seq_gen_pkg;

  localparam int unsigned STATE_W     = 2;
  localparam int unsigned DEF_NPHASE  = 8;
  localparam int unsigned DEF_PW      = 3;
  localparam int unsigned DEF_ALU_ST  = 1;
  localparam int unsigned DEF_ALU_SP  = 1;
  localparam int unsigned DEF_FET_ST  = 4;
  localparam int unsigned DEF_FET_SP  = 7;
  localparam int unsigned DEF_NCH     = 2;
  localparam int unsigned DEF_CW      = 16;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } state_e;

  // Strobes and the cycle-start flag are only live while executing a cycle
  function automatic logic is_active(input state_e s);
    return (s == S_RUN) || (s == S_STEP);
  endfunction

endpackage

// File: rtl/phase_window.sv
// Registered strobe: high for next phases ST..SP while the sequencer is executing a cycle.
module phase_window #(
  parameter int unsigned NPHASE = 8,
  parameter int unsigned PW     = 3,
  parameter int unsigned ST     = 0,
  parameter int unsigned SP     = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [PW-1:0] nxt_phase,
  input  logic          active,
  output logic          win
);

  logic lo_ok;
  logic hi_ok;
  logic win_d;
  logic win_q;

  // Window bounds must lie inside the cycle and must not wrap
  if (ST > SP || SP >= NPHASE) begin : g_bad_window
    $error("phase_window: illegal window ST=%0d SP=%0d NPHASE=%0d", ST, SP, NPHASE);
  end

  // Bound comparisons that are trivially true are elided
  if (ST == 0) begin : g_lo_all
    assign lo_ok = 1'b1;
  end else begin : g_lo_cmp
    assign lo_ok = (nxt_phase >= PW'(ST));
  end

  if (SP >= (2 ** PW) - 1) begin : g_hi_all
    assign hi_ok = 1'b1;
  end else begin : g_hi_cmp
    assign hi_ok = (nxt_phase <= PW'(SP));
  end

  assign win_d = active & lo_ok & hi_ok;

  // Strobe register, updated on the falling edge like the rest of the sequencer
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= 1'b0;
    end else begin
      win_q <= win_d;
    end
  end

  assign win = win_q;

endmodule

// File: rtl/phase_seq_gen.sv
// Parametrised instruction-cycle phase sequencer with halt, single-step, stall and cycle counter.
module phase_seq_gen
  import phase_seq_gen_pkg::*;
#(
  parameter int unsigned     NPHASE = DEF_NPHASE,
  parameter int unsigned     PW     = DEF_PW,
  parameter int unsigned     ALU_ST = DEF_ALU_ST,
  parameter int unsigned     ALU_SP = DEF_ALU_SP,
  parameter int unsigned     FET_ST = DEF_FET_ST,
  parameter int unsigned     FET_SP = DEF_FET_SP,
  parameter int unsigned     NCH    = DEF_NCH,
  parameter logic [NCH*PW-1:0] CH_ST = {3'd2, 3'd0},
  parameter logic [NCH*PW-1:0] CH_SP = {3'd3, 3'd0},
  parameter int unsigned     CW     = DEF_CW
) (
  input  logic           CLOCK,
  input  logic           RESET_N,
  input  logic           STALL,
  input  logic           HALT_REQ,
  input  logic           STEP,
  output logic           CLK_CTRL,
  output logic           CLK_ALU,
  output logic           CLK_FETCH,
  output logic [NCH-1:0] STROBE,
  output logic [PW-1:0]  PHASE,
  output logic           CYC_START,
  output logic           HALTED,
  output logic [CW-1:0]  CYC_CNT
);

  localparam logic [PW-1:0] LAST_PHASE = PW'(NPHASE - 1);

  if ((2 ** PW) < NPHASE || NPHASE < 2) begin : g_bad_cfg
    $error("phase_seq_gen: illegal NPHASE=%0d for PW=%0d", NPHASE, PW);
  end

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cyc_start_q, cyc_start_d;
  logic          halted_q, halted_d;
  logic          active_d;

  // State, phase and cycle-count registers
  always_ff @(negedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      cnt_q       <= '0;
      cyc_start_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      cyc_start_q <= cyc_start_d;
      halted_q    <= halted_d;
    end
  end

  // Next-state: stall freezes everything except a parked sequencer; halt only at a cycle boundary
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (!(STALL && state_q != S_HALT)) begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RUN;
          phase_d = '0;
        end
        S_RUN, S_STEP: begin
          if (phase_q == LAST_PHASE) begin
            cnt_d   = cnt_q + CW'(1);
            phase_d = '0;
            state_d = HALT_REQ ? S_HALT : S_RUN;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        S_HALT: begin
          phase_d = '0;
          if (STEP) begin
            state_d = S_STEP;
          end else if (!HALT_REQ) begin
            state_d = S_RUN;
          end
        end
        default: begin
          state_d = S_IDLE;
          phase_d = '0;
        end
      endcase
    end
    active_d    = is_active(state_d);
    cyc_start_d = active_d && (phase_d == '0);
    halted_d    = (state_d == S_HALT);
  end

  phase_window #(.NPHASE(NPHASE), .PW(PW), .ST(ALU_ST), .SP(ALU_SP)) u_alu_win (
    .clk(CLOCK), .rst_n(RESET_N), .nxt_phase(phase_d), .active(active_d), .win(CLK_ALU)
  );

  phase_window #(.NPHASE(NPHASE), .PW(PW), .ST(FET_ST), .SP(FET_SP)) u_fet_win (
    .clk(CLOCK), .rst_n(RESET_N), .nxt_phase(phase_d), .active(active_d), .win(CLK_FETCH)
  );

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    phase_window #(
      .NPHASE(NPHASE),
      .PW(PW),
      .ST(32'(CH_ST[i*PW +: PW])),
      .SP(32'(CH_SP[i*PW +: PW]))
    ) u_ch_win (
      .clk(CLOCK), .rst_n(RESET_N), .nxt_phase(phase_d), .active(active_d), .win(STROBE[i])
    );
  end

  assign CLK_CTRL  = ~CLOCK;
  assign PHASE     = phase_q;
  assign CYC_CNT   = cnt_q;
  assign CYC_START = cyc_start_q;
  assign HALTED    = halted_q;

endmodule

// File: tb/tb_phase_seq_gen.sv
// Bench for phase_seq_gen: default 8-phase instance plus a 5-phase / 2-bit-counter instance.
module tb_phase_seq_gen;

  logic CLOCK    = 1'b1;
  logic RESET_N  = 1'b1;
  logic STALL    = 1'b0;
  logic HALT_REQ = 1'b0;
  logic STEP     = 1'b0;
  logic chk_en   = 1'b0;

  logic       ctrl_a, alu_a, fet_a, cs_a, halted_a;
  logic [1:0] strobe_a;
  logic [2:0] phase_a;
  logic [15:0] cnt_a;

  logic       ctrl_b, alu_b, fet_b, cs_b, halted_b;
  logic [1:0] strobe_b;
  logic [2:0] phase_b;
  logic [1:0] cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 CLOCK = ~CLOCK;

  phase_seq_gen u_dut_a (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .STALL(STALL), .HALT_REQ(HALT_REQ), .STEP(STEP),
    .CLK_CTRL(ctrl_a), .CLK_ALU(alu_a), .CLK_FETCH(fet_a), .STROBE(strobe_a),
    .PHASE(phase_a), .CYC_START(cs_a), .HALTED(halted_a), .CYC_CNT(cnt_a)
  );

  phase_seq_gen #(
    .NPHASE(5), .PW(3), .ALU_ST(1), .ALU_SP(1), .FET_ST(2), .FET_SP(4), .NCH(2),
    .CH_ST({3'd4, 3'd0}), .CH_SP({3'd4, 3'd1}), .CW(2)
  ) u_dut_b (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .STALL(STALL), .HALT_REQ(HALT_REQ), .STEP(STEP),
    .CLK_CTRL(ctrl_b), .CLK_ALU(alu_b), .CLK_FETCH(fet_b), .STROBE(strobe_b),
    .PHASE(phase_b), .CYC_START(cs_b), .HALTED(halted_b), .CYC_CNT(cnt_b)
  );

  // Model configuration: windows are alu, fetch, ch0, ch1
  int np     [2] = '{8, 5};
  int cw_mod [2] = '{65536, 4};
  int win_st [2][4] = '{'{1, 4, 0, 2}, '{1, 2, 0, 4}};
  int win_sp [2][4] = '{'{1, 7, 0, 3}, '{1, 4, 1, 4}};

  // Model state: executing a cycle, parked, current phase, completed cycles
  bit m_active [2] = '{1'b0, 1'b0};
  bit m_halt   [2] = '{1'b0, 1'b0};
  int m_phase  [2] = '{0, 0};
  int m_cyc    [2] = '{0, 0};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_win(input int k, input int w);
    return int'(m_active[k] && m_phase[k] >= win_st[k][w] && m_phase[k] <= win_sp[k][w]);
  endfunction

  // Behavioural model of the sequencer rules
  always @(negedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int k = 0; k < 2; k++) begin
        m_active[k] = 1'b0;
        m_halt[k]   = 1'b0;
        m_phase[k]  = 0;
        m_cyc[k]    = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_halt[k]) begin
          m_phase[k] = 0;
          if (STEP || !HALT_REQ) begin
            m_halt[k]   = 1'b0;
            m_active[k] = 1'b1;
          end
        end else if (!STALL) begin
          if (!m_active[k]) begin
            m_active[k] = 1'b1;
            m_phase[k]  = 0;
          end else if (m_phase[k] == np[k] - 1) begin
            m_cyc[k]   = (m_cyc[k] + 1) % cw_mod[k];
            m_phase[k] = 0;
            if (HALT_REQ) begin
              m_active[k] = 1'b0;
              m_halt[k]   = 1'b1;
            end
          end else begin
            m_phase[k] = m_phase[k] + 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(posedge CLOCK) begin
    if (chk_en) begin
      chk("a_phase",  int'(phase_a),     m_phase[0]);
      chk("a_cnt",    int'(cnt_a),       m_cyc[0]);
      chk("a_halted", int'(halted_a),    int'(m_halt[0]));
      chk("a_cstart", int'(cs_a),        int'(m_active[0] && m_phase[0] == 0));
      chk("a_alu",    int'(alu_a),       exp_win(0, 0));
      chk("a_fetch",  int'(fet_a),       exp_win(0, 1));
      chk("a_str0",   int'(strobe_a[0]), exp_win(0, 2));
      chk("a_str1",   int'(strobe_a[1]), exp_win(0, 3));
      chk("b_phase",  int'(phase_b),     m_phase[1]);
      chk("b_cnt",    int'(cnt_b),       m_cyc[1]);
      chk("b_halted", int'(halted_b),    int'(m_halt[1]));
      chk("b_cstart", int'(cs_b),        int'(m_active[1] && m_phase[1] == 0));
      chk("b_alu",    int'(alu_b),       exp_win(1, 0));
      chk("b_fetch",  int'(fet_b),       exp_win(1, 1));
      chk("b_str0",   int'(strobe_b[0]), exp_win(1, 2));
      chk("b_str1",   int'(strobe_b[1]), exp_win(1, 3));
    end
  end

  task automatic sample();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic wait_phase_a(input int v, input string nm);
    int n;
    n = 0;
    do begin
      sample();
      n++;
    end while (int'(phase_a) != v && n < 40);
    chk(nm, int'(phase_a), v);
  endtask

  initial begin
    // Reset values
    #1 RESET_N = 1'b0;
    #1;
    chk("rst_phase",  int'(phase_a),  0);
    chk("rst_cnt",    int'(cnt_a),    0);
    chk("rst_halted", int'(halted_a), 0);
    chk("rst_alu",    int'(alu_a),    0);
    chk("rst_fetch",  int'(fet_a),    0);
    chk("rst_strobe", int'(strobe_a), 0);
    @(posedge CLOCK);
    @(posedge CLOCK);
    RESET_N = 1'b1;
    chk_en  = 1'b1;

    // T1: free run, stray STEP while running is ignored
    for (int i = 0; i < 20; i++) begin
      sample();
      STEP = (i == 10);
      chk("t1_phase", int'(phase_a), i % 8);
      chk("t1_alu",   int'(alu_a),   int'(i % 8 == 1));
      chk("t1_fetch", int'(fet_a),   int'(i % 8 >= 4));
    end
    STEP = 1'b0;
    chk("t1_cnt", int'(cnt_a), 2);

    // T2: halt request mid-cycle completes the cycle first
    wait_phase_a(2, "t2_wait2");
    chk("t2_cnt_pre", int'(cnt_a), 3);
    HALT_REQ = 1'b1;
    repeat (5) sample();
    chk("t2_phase7",  int'(phase_a),  7);
    chk("t2_not_hlt", int'(halted_a), 0);
    sample();
    chk("t2_halted", int'(halted_a), 1);
    chk("t2_phase",  int'(phase_a),  0);
    chk("t2_alu",    int'(alu_a),    0);
    chk("t2_fetch",  int'(fet_a),    0);
    chk("t2_strobe", int'(strobe_a), 0);
    chk("t2_cstart", int'(cs_a),     0);
    chk("t2_cnt",    int'(cnt_a),    4);
    repeat (2) sample();
    chk("t2_hold", int'(halted_a), 1);

    // T3: single step runs exactly one cycle then parks again
    STEP = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample();
      if (i == 0) STEP = 1'b0;
      chk("t3_phase",  int'(phase_a),  i);
      chk("t3_halted", int'(halted_a), 0);
      chk("t3_alu",    int'(alu_a),    int'(i == 1));
      chk("t3_fetch",  int'(fet_a),    int'(i >= 4));
    end
    sample();
    chk("t3_rehalt", int'(halted_a), 1);
    chk("t3_cnt",    int'(cnt_a),    5);

    // T4: stall freezes phase and strobes
    HALT_REQ = 1'b0;
    wait_phase_a(4, "t4_wait4");
    chk("t4_fetch_pre", int'(fet_a), 1);
    STALL = 1'b1;
    repeat (3) begin
      sample();
      chk("t4_stall_ph", int'(phase_a), 4);
      chk("t4_stall_fe", int'(fet_a),   1);
    end
    STALL = 1'b0;
    sample();
    chk("t4_resume", int'(phase_a), 5);

    // T5: asynchronous reset mid-phase
    #1 RESET_N = 1'b0;
    #1;
    chk("t5_phase_a",  int'(phase_a),  0);
    chk("t5_cnt_a",    int'(cnt_a),    0);
    chk("t5_fetch_a",  int'(fet_a),    0);
    chk("t5_strobe_a", int'(strobe_a), 0);
    chk("t5_cstart_a", int'(cs_a),     0);
    chk("t5_phase_b",  int'(phase_b),  0);
    chk("t5_cnt_b",    int'(cnt_b),    0);
    @(posedge CLOCK);
    RESET_N = 1'b1;

    // T6: 5-phase instance windows and 2-bit counter wrap
    for (int i = 0; i < 25; i++) begin
      sample();
      chk("t6_phase_a", int'(phase_a),     i % 8);
      chk("t6_phase_b", int'(phase_b),     i % 5);
      chk("t6_str0_b",  int'(strobe_b[0]), int'(i % 5 <= 1));
      chk("t6_str1_b",  int'(strobe_b[1]), int'(i % 5 == 4));
      chk("t6_fet_b",   int'(fet_b),       int'(i % 5 >= 2));
      chk("t6_cnt_b",   int'(cnt_b),       (i / 5) % 4);
    end

    // CLK_CTRL follows the inverted clock
    chk("ctrl_hi_clk_a", int'(ctrl_a), 0);
    chk("ctrl_hi_clk_b", int'(ctrl_b), 0);
    @(negedge CLOCK);
    #1;
    chk("ctrl_lo_clk_a", int'(ctrl_a), 1);
    chk("ctrl_lo_clk_b", int'(ctrl_b), 1);

    sample();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
